// File: rtl/sprite_pkg.sv
// Shared sprite types, register offsets and colour helpers for sprite_compositor.
package sprite_pkg;

    localparam int unsigned RegX     = 0;
    localparam int unsigned RegY     = 1;
    localparam int unsigned RegSize  = 2;
    localparam int unsigned RegColor = 3;
    localparam int unsigned VACTIVE  = 480;
    localparam logic [15:0] BgReset  = 16'h0010;

    typedef struct packed {
        logic        en;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [15:0] rgb565;
    } sprite_t;

    // Widen each channel by replicating its MSBs into the new low bits
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// One sprite channel: rectangle hit test for the current pixel, registered into S1.
module sprite_hit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [7:0] w,
    input  logic [7:0] h,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       hit
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        hit_d;
    logic        hit_q;

    // 11-bit ends: a rectangle running past the screen edge clips rather than wraps
    always_comb begin
        x_end = {1'b0, x} + {3'b000, w};
        y_end = {1'b0, y} + {3'b000, h};
        hit_d = en && (px >= x) && ({1'b0, px} < x_end) && (py >= y) && ({1'b0, py} < y_end);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay stage with frame-committed shadow registers, 2-clock pixel latency.
// Optional sticky player collision reporting is built when COLLISION_DETECT_EN is defined.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPRITES = 4,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              blank_n_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n
);

    localparam logic [ADDR_W-1:0] BgAddr     = ADDR_W'(4 * N_SPRITES);
    localparam logic [ADDR_W-1:0] StatusAddr = ADDR_W'(4 * N_SPRITES + 1);

    sprite_t              shadow_q [N_SPRITES];
    sprite_t              active_q [N_SPRITES];
    logic [15:0]          bg_shadow_q;
    logic [15:0]          bg_active_q;
    logic [7:0]           frame_q;
    logic [N_SPRITES-1:0] hit_s1;
    logic                 blank_s1_q;
    logic                 hs_s1_q;
    logic                 vs_s1_q;
    logic [6:0]           coll_bits;
    logic [15:0]          rd_data;
    logic [23:0]          pix_d;
    logic                 wr_en;
    logic                 rd_en;
    logic                 commit;

    assign wr_en  = chipselect && write;
    assign rd_en  = chipselect && read;
    assign commit = (vcount == 10'(VACTIVE)) && (hcount == '0);

    // Nonblocking copy means a write on the commit cycle misses this frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            bg_shadow_q <= BgReset;
            bg_active_q <= BgReset;
            frame_q     <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    if (address == ADDR_W'(4 * i + RegX)) begin
                        shadow_q[i].en <= writedata[15];
                        shadow_q[i].x  <= writedata[9:0];
                    end
                    if (address == ADDR_W'(4 * i + RegY))     shadow_q[i].y      <= writedata[9:0];
                    if (address == ADDR_W'(4 * i + RegSize))  shadow_q[i].h      <= writedata[15:8];
                    if (address == ADDR_W'(4 * i + RegSize))  shadow_q[i].w      <= writedata[7:0];
                    if (address == ADDR_W'(4 * i + RegColor)) shadow_q[i].rgb565 <= writedata;
                end
                if (address == BgAddr) bg_shadow_q <= writedata;
            end
            if (commit) begin
                for (int i = 0; i < N_SPRITES; i++) active_q[i] <= shadow_q[i];
                bg_active_q <= bg_shadow_q;
                frame_q     <= frame_q + 8'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (address == ADDR_W'(4 * i + RegX))     rd_data = {shadow_q[i].en, 5'b0, shadow_q[i].x};
            if (address == ADDR_W'(4 * i + RegY))     rd_data = {6'b0, shadow_q[i].y};
            if (address == ADDR_W'(4 * i + RegSize))  rd_data = {shadow_q[i].h, shadow_q[i].w};
            if (address == ADDR_W'(4 * i + RegColor)) rd_data = shadow_q[i].rgb565;
        end
        if (address == BgAddr)     rd_data = bg_shadow_q;
        if (address == StatusAddr) rd_data = {frame_q, coll_bits, 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_data;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_chan
        sprite_hit u_hit (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (active_q[g].en),
            .x       (active_q[g].x),
            .y       (active_q[g].y),
            .w       (active_q[g].w),
            .h       (active_q[g].h),
            .px      (hcount[10:1]),
            .py      (vcount),
            .hit     (hit_s1[g])
        );
    end

`ifdef COLLISION_DETECT_EN
    logic [6:0] coll_set;
    logic [6:0] coll_q;
    logic       status_rd;

    assign status_rd = rd_en && (address == StatusAddr);

    always_comb begin
        coll_set = '0;
        for (int i = 1; i < N_SPRITES; i++) begin
            coll_set[i-1] = blank_s1_q && hit_s1[0] && hit_s1[i];
        end
    end

    // A fresh hit in the read cycle survives the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coll_q <= '0;
        end else if (status_rd) begin
            coll_q <= coll_set;
        end else begin
            coll_q <= coll_q | coll_set;
        end
    end

    assign coll_bits = coll_q;
`else
    assign coll_bits = '0;
`endif

    always_comb begin
        pix_d = rgb565_to_888(bg_active_q);
        for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
            if (hit_s1[i]) pix_d = rgb565_to_888(active_q[i].rgb565);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_s1_q  <= 1'b0;
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
        end else begin
            blank_s1_q  <= blank_n_in;
            hs_s1_q     <= hs_in;
            vs_s1_q     <= vs_in;
            VGA_R       <= blank_s1_q ? pix_d[23:16] : 8'h00;
            VGA_G       <= blank_s1_q ? pix_d[15:8]  : 8'h00;
            VGA_B       <= blank_s1_q ? pix_d[7:0]   : 8'h00;
            VGA_HS      <= hs_s1_q;
            VGA_VS      <= vs_s1_q;
            VGA_BLANK_n <= blank_s1_q;
        end
    end

endmodule
